// File: rtl/do_ra_mi_pkg.sv
// Shared constants, pitch tables and the half-period helper for the do_ra_mi tone generator.
// DO_RA_MI_CHROMATIC_EN selects the semitone table instead of the diatonic one.
package do_ra_mi_pkg;

  localparam logic [4:0] NOTE_REST = 5'd0;
  localparam logic [4:0] NOTE_MAX  = 5'd19;

  function automatic int freq_diatonic(input logic [4:0] idx);
    case (idx)
      5'd1:    return 32'd262;
      5'd2:    return 32'd294;
      5'd3:    return 32'd330;
      5'd4:    return 32'd349;
      5'd5:    return 32'd392;
      5'd6:    return 32'd440;
      5'd7:    return 32'd494;
      5'd8:    return 32'd523;
      5'd9:    return 32'd587;
      5'd10:   return 32'd659;
      5'd11:   return 32'd698;
      5'd12:   return 32'd784;
      5'd13:   return 32'd880;
      5'd14:   return 32'd988;
      5'd15:   return 32'd1047;
      5'd16:   return 32'd1175;
      5'd17:   return 32'd1319;
      5'd18:   return 32'd1397;
      5'd19:   return 32'd1568;
      default: return 32'd0;
    endcase
  endfunction

  // Semitones from C4: 261.63 * 2^((n-1)/12) rounded to the nearest Hz.
  function automatic int freq_chromatic(input logic [4:0] idx);
    case (idx)
      5'd1:    return 32'd262;
      5'd2:    return 32'd277;
      5'd3:    return 32'd294;
      5'd4:    return 32'd311;
      5'd5:    return 32'd330;
      5'd6:    return 32'd349;
      5'd7:    return 32'd370;
      5'd8:    return 32'd392;
      5'd9:    return 32'd415;
      5'd10:   return 32'd440;
      5'd11:   return 32'd466;
      5'd12:   return 32'd494;
      5'd13:   return 32'd523;
      5'd14:   return 32'd554;
      5'd15:   return 32'd587;
      5'd16:   return 32'd622;
      5'd17:   return 32'd659;
      5'd18:   return 32'd698;
      5'd19:   return 32'd740;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int half_period(input int clk_hz, input logic [4:0] idx);
    int f;
`ifdef DO_RA_MI_CHROMATIC_EN
    f = freq_chromatic(idx);
`else
    f = freq_diatonic(idx);
`endif
    if (f == 32'd0) begin
      return 32'd0;
    end else begin
      return clk_hz / (32'd2 * f);
    end
  endfunction

endpackage

// File: rtl/do_ra_mi_tone_divider.sv
// Half-period counter and toggle flop: restart clears the phase without touching the output,
// a disabled (rest) divider parks the output low.
module tone_divider
  import do_ra_mi_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] i_half,
  input  logic             i_restart,
  input  logic             i_en,
  output logic             o_sq
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_sq;
  logic             w_terminal;

  assign w_terminal = (r_cnt == (i_half - ONE));

  // Phase counter with compare-and-clear at HALF-1, so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= {CNT_W{1'b0}};
      r_sq  <= 1'b0;
    end else if (i_restart) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (!i_en) begin
      r_cnt <= {CNT_W{1'b0}};
      r_sq  <= 1'b0;
    end else if (w_terminal) begin
      r_cnt <= {CNT_W{1'b0}};
      r_sq  <= ~r_sq;
    end else begin
      r_cnt <= r_cnt + ONE;
    end
  end

  assign o_sq = r_sq;

endmodule

// File: rtl/do_ra_mi.sv
// Square-wave tone generator: note index -> 50 % duty tone via a constant half-period ROM.
// Build option DO_RA_MI_CHROMATIC_EN switches the pitch table to semitones (see package).
module do_ra_mi
  import do_ra_mi_pkg::*;
#(
  parameter int CLK_HZ = 25_000_000,
  parameter int CNT_W  = $clog2(CLK_HZ / 524) + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] note,
  output logic       squareWave
);

  logic [4:0]       r_note_q;
  logic             w_change;
  logic             w_en;
  logic [CNT_W-1:0] w_half;

  // Registered copy of the note index for change detection and table lookup.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_note_q <= NOTE_REST;
    end else begin
      r_note_q <= note;
    end
  end

  assign w_change = (note != r_note_q);
  assign w_en     = (r_note_q != NOTE_REST) && (r_note_q <= NOTE_MAX);

  // Half-period ROM; every entry folds to a constant at elaboration.
  always_comb begin
    w_half = {CNT_W{1'b0}};
    case (r_note_q)
      5'd1:    w_half = CNT_W'(half_period(CLK_HZ, 5'd1));
      5'd2:    w_half = CNT_W'(half_period(CLK_HZ, 5'd2));
      5'd3:    w_half = CNT_W'(half_period(CLK_HZ, 5'd3));
      5'd4:    w_half = CNT_W'(half_period(CLK_HZ, 5'd4));
      5'd5:    w_half = CNT_W'(half_period(CLK_HZ, 5'd5));
      5'd6:    w_half = CNT_W'(half_period(CLK_HZ, 5'd6));
      5'd7:    w_half = CNT_W'(half_period(CLK_HZ, 5'd7));
      5'd8:    w_half = CNT_W'(half_period(CLK_HZ, 5'd8));
      5'd9:    w_half = CNT_W'(half_period(CLK_HZ, 5'd9));
      5'd10:   w_half = CNT_W'(half_period(CLK_HZ, 5'd10));
      5'd11:   w_half = CNT_W'(half_period(CLK_HZ, 5'd11));
      5'd12:   w_half = CNT_W'(half_period(CLK_HZ, 5'd12));
      5'd13:   w_half = CNT_W'(half_period(CLK_HZ, 5'd13));
      5'd14:   w_half = CNT_W'(half_period(CLK_HZ, 5'd14));
      5'd15:   w_half = CNT_W'(half_period(CLK_HZ, 5'd15));
      5'd16:   w_half = CNT_W'(half_period(CLK_HZ, 5'd16));
      5'd17:   w_half = CNT_W'(half_period(CLK_HZ, 5'd17));
      5'd18:   w_half = CNT_W'(half_period(CLK_HZ, 5'd18));
      5'd19:   w_half = CNT_W'(half_period(CLK_HZ, 5'd19));
      default: w_half = {CNT_W{1'b0}};
    endcase
  end

  tone_divider #(
    .CNT_W(CNT_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .i_half   (w_half),
    .i_restart(w_change),
    .i_en     (w_en),
    .o_sq     (squareWave)
  );

endmodule

// File: tb/tb_do_ra_mi.sv
// Self-checking bench for do_ra_mi at CLK_HZ=52400 with a phase-arithmetic reference model.
module tb_do_ra_mi;

  localparam int CLK_HZ = 52400;

`ifdef DO_RA_MI_CHROMATIC_EN
  localparam int FREQ [0:19] = '{0, 262, 277, 294, 311, 330, 349, 370, 392, 415, 440,
                                 466, 494, 523, 554, 587, 622, 659, 698, 740};
`else
  localparam int FREQ [0:19] = '{0, 262, 294, 330, 349, 392, 440, 494, 523, 587, 659,
                                 698, 784, 880, 988, 1047, 1175, 1319, 1397, 1568};
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] note = 5'd0;
  logic       squareWave;

  int   errors = 0;
  int   checks = 0;
  int   e = 0;
  int   m_prev = 0;
  int   m_t0 = 0;
  logic m_out = 1'b0;
  logic m_lvl = 1'b0;

  do_ra_mi #(.CLK_HZ(CLK_HZ)) dut (
    .clk       (clk),
    .rst       (rst),
    .note      (note),
    .squareWave(squareWave)
  );

  always #5 clk = ~clk;

  function automatic int half_of(input int n);
    if (n < 1 || n > 19) return 0;
    return CLK_HZ / (2 * FREQ[n]);
  endfunction

  // Advance one edge; the model tracks level at last note change and counts whole half periods since.
  task automatic step();
    @(posedge clk);
    e++;
    if (rst) begin
      m_out  = 1'b0;
      m_prev = 0;
    end else if (int'(note) != m_prev) begin
      m_prev = int'(note);
      m_t0   = e;
      m_lvl  = m_out;
    end else if (half_of(m_prev) == 0) begin
      m_out = 1'b0;
    end else begin
      m_out = m_lvl ^ ((((e - m_t0) / half_of(m_prev)) % 2) == 1);
    end
    #1;
  endtask

  task automatic run_until(input logic lvl, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (squareWave !== lvl && n < 1000);
  endtask

  task automatic test_reset();
    int n;
    rst  = 1'b1;
    note = 5'd6;
    repeat (500) begin
      step();
      checks++;
      if (squareWave !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: got %b expected 0", squareWave);
      end
    end
    rst = 1'b0;
    run_until(1'b1, n);
    checks++;
    if (n !== half_of(6) + 1) begin
      errors++;
      $display("FAIL first_rise: got %0d edges expected %0d", n, half_of(6) + 1);
    end
    run_until(1'b0, n);
    checks++;
    if (n !== half_of(6)) begin
      errors++;
      $display("FAIL high_phase: got %0d expected %0d", n, half_of(6));
    end
    run_until(1'b1, n);
    checks++;
    if (n !== half_of(6)) begin
      errors++;
      $display("FAIL low_phase: got %0d expected %0d", n, half_of(6));
    end
  endtask

  task automatic test_switch_while_high();
    int n;
    note = 5'd1;
    run_until(1'b0, n);
    checks++;
    if (n !== half_of(1) + 1) begin
      errors++;
      $display("FAIL switch_hold: got %0d edges expected %0d", n, half_of(1) + 1);
    end
  endtask

  task automatic test_period();
    int nh;
    int nl;
    for (int i = 0; i < 10; i++) begin
      run_until(1'b1, nl);
      run_until(1'b0, nh);
      checks++;
      if (nl !== half_of(1) || nh !== half_of(1)) begin
        errors++;
        $display("FAIL period_%0d: got low=%0d high=%0d expected %0d each", i, nl, nh, half_of(1));
      end
      checks++;
      if (squareWave !== m_out) begin
        errors++;
        $display("FAIL period_model: got %b expected %b", squareWave, m_out);
      end
    end
  endtask

  task automatic test_rest(input logic [4:0] rn);
    int hi;
    note = 5'd6;
    repeat (200) begin
      step();
      checks++;
      if (squareWave !== m_out) begin
        errors++;
        $display("FAIL rest_pre_model: got %b expected %b", squareWave, m_out);
      end
    end
    note = rn;
    step();
    step();
    checks++;
    if (squareWave !== 1'b0) begin
      errors++;
      $display("FAIL rest_%0d_low: got %b expected 0", rn, squareWave);
    end
    hi = 0;
    repeat (1000) begin
      step();
      if (squareWave !== 1'b0) hi++;
    end
    checks++;
    if (hi !== 0) begin
      errors++;
      $display("FAIL rest_%0d_stays_low: got %0d high cycles expected 0", rn, hi);
    end
  endtask

  task automatic test_async_reset();
    int n;
    note = 5'd6;
    run_until(1'b1, n);
    checks++;
    if (n !== half_of(6) + 1) begin
      errors++;
      $display("FAIL rest_to_pitch_rise: got %0d expected %0d", n, half_of(6) + 1);
    end
    repeat (20) step();
    checks++;
    if (squareWave !== 1'b1) begin
      errors++;
      $display("FAIL mid_high: got %b expected 1", squareWave);
    end
    rst = 1'b1;
    #1;
    m_out  = 1'b0;
    m_prev = 0;
    checks++;
    if (squareWave !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got %b expected 0", squareWave);
    end
    repeat (3) step();
    rst = 1'b0;
    run_until(1'b1, n);
    checks++;
    if (n !== half_of(6) + 1) begin
      errors++;
      $display("FAIL post_reset_rise: got %0d expected %0d", n, half_of(6) + 1);
    end
  endtask

  task automatic test_rapid();
    logic lvl;
    int   bad;
    lvl = squareWave;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      note = (i % 2 == 0) ? 5'd1 : 5'd6;
      step();
      if (squareWave !== lvl || squareWave !== m_out) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL rapid_changes: got %0d deviating cycles expected 0", bad);
    end
  endtask

  task automatic test_table_note(input logic [4:0] k);
    int n;
    note = 5'd0;
    step();
    step();
    note = k;
    run_until(1'b1, n);
    checks++;
    if (n !== half_of(k) + 1) begin
      errors++;
      $display("FAIL note%0d_first_rise: got %0d expected %0d", k, n, half_of(k) + 1);
    end
    run_until(1'b0, n);
    checks++;
    if (n !== half_of(k)) begin
      errors++;
      $display("FAIL note%0d_half: got %0d expected %0d", k, n, half_of(k));
    end
  endtask

  task automatic test_random();
    int hold;
    int r;
    int bad;
    for (int s = 0; s < 30; s++) begin
      r = int'($urandom_range(0, 3));
      if (r == 0) note = 5'($urandom_range(20, 31));
      else if (r == 1) note = 5'd0;
      else note = 5'($urandom_range(1, 19));
      hold = int'($urandom_range(1, 400));
      bad  = 0;
      repeat (hold) begin
        step();
        if (squareWave !== m_out) bad++;
      end
      checks++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL random_seg%0d_note%0d: got %0d bad cycles expected 0", s, note, bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_switch_while_high();
    test_period();
    test_rest(5'd0);
    test_rest(5'd25);
    test_async_reset();
    test_rapid();
    test_table_note(5'd10);
    test_table_note(5'd19);
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
